// File: rtl/serial_port_arbiter.sv
// Round-robin output-port scheduler for one serial router link: grants one
// ready input port per frame and shifts its item out as start bit + LSB-first data.
module serial_port_arbiter #(
  parameter int N    = 5,
  parameter int SIZE = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        in_valid,
  input  logic [N*SIZE-1:0]   in_data,
  output logic [N-1:0]        in_read,
  input  logic                channel_busy,
  output logic                serial_out,
  output logic [N-1:0]        grant,
  output logic                active
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [SIZE-1:0] shift_q;
  logic [CW-1:0]   bit_cnt;

  logic [PW-1:0]   lo_idx;
  logic [PW-1:0]   hi_idx;
  logic            hi_found;
  logic [PW-1:0]   sel_idx;
  logic            sel_found;
  logic [N-1:0]    sel_onehot;
  logic [SIZE-1:0] sel_data;

  // Round-robin pick: lowest requester above ptr, otherwise wrap to the lowest overall.
  always_comb begin
    lo_idx     = '0;
    hi_idx     = '0;
    hi_found   = 1'b0;
    sel_onehot = '0;
    sel_data   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        lo_idx = PW'(i);
        if (PW'(i) > ptr) begin
          hi_idx   = PW'(i);
          hi_found = 1'b1;
        end
      end
    end
    sel_found = (in_valid != '0);
    sel_idx   = hi_found ? hi_idx : lo_idx;
    for (int i = 0; i < N; i++) begin
      if (PW'(i) == sel_idx) begin
        sel_onehot[i] = 1'b1;
        sel_data      = in_data[i*SIZE +: SIZE];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ptr        <= PW'(N - 1);
      shift_q    <= '0;
      bit_cnt    <= '0;
      serial_out <= 1'b0;
      in_read    <= '0;
      grant      <= '0;
      active     <= 1'b0;
    end else begin
      in_read <= '0;
      case (state)
        ST_IDLE: begin
          serial_out <= 1'b0;
          if (!channel_busy && sel_found) begin
            ptr        <= sel_idx;
            grant      <= sel_onehot;
            in_read    <= sel_onehot;
            shift_q    <= sel_data;
            bit_cnt    <= '0;
            serial_out <= 1'b1;
            active     <= 1'b1;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          // bit_cnt == SIZE means the last data bit has already had its full cycle.
          if (bit_cnt == CW'(SIZE)) begin
            serial_out <= 1'b0;
            state      <= ST_WAIT;
          end else begin
            serial_out <= shift_q[0];
            shift_q    <= shift_q >> 1;
            bit_cnt    <= bit_cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          serial_out <= 1'b0;
          if (!channel_busy) begin
            grant  <= '0;
            active <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
